// File: rtl/spi_sync.sv
// Multi-stage flop synchroniser of parameterised width, used to bring the
// SPI-domain strobe and address decode into the clk domain.
module spi_sync #(
   parameter int unsigned W  = 1,
   parameter int unsigned NS = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] stage_q [NS];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NS; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d_i;
         for (int unsigned i = 1; i < NS; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[NS-1];

endmodule

// File: rtl/spi_slave_regbank_r.sv
// Bank of m read-only registers read by the SPI master; clk-domain writes are
// deferred while a register is addressed so the master never sees a torn value.
module spi_slave_regbank_r #(
   parameter int unsigned   n   = 8,
   parameter int unsigned   m   = 4,
   parameter logic [n-1:0]  a   = '0,
   parameter logic [m-1:0]  cor = '0,
   parameter int unsigned   ns  = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           strobe,
   input  logic [n-1:0]   addr,
   output logic [n-1:0]   in,
   output logic           zo,
   input  logic [m*n-1:0] d,
   input  logic [m-1:0]   we,
   input  logic [m-1:0]   ovf_clr,
   output logic [m-1:0]   rd_pulse,
   output logic [m-1:0]   fresh,
   output logic [m-1:0]   ovf
);

   localparam int unsigned k = $clog2(m);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t              state_q, state_d;
   logic [k-1:0]        ri_q, ri_d;
   logic                ss_prev_q;
   logic [m-1:0]        frz_q, frz, rc;
   logic                rc_any;
   logic [m-1:0][n-1:0] bank_q, bank_d, pend_q, pend_d;
   logic [m-1:0]        pv_q, pv_d, fresh_q, fresh_d, ovf_q, ovf_d, rd_pulse_q;

   logic                hit;
   logic [k-1:0]        idx;
   logic                ss, sh;
   logic [k-1:0]        si;
   logic [k:0]          sync_addr;

   assign hit = (addr[n-1:k] == a[n-1:k]);
   assign idx = addr[k-1:0];

   // Read path is purely combinational in the SPI domain.
   assign in = (strobe && hit) ? bank_q[idx] : '0;
   assign zo = ~(strobe && hit);

   spi_sync #(.W(1), .NS(ns)) u_sync_strobe (
      .clk_i(clk), .rst_i(rst), .d_i(strobe), .q_o(ss)
   );

   spi_sync #(.W(k+1), .NS(ns)) u_sync_addr (
      .clk_i(clk), .rst_i(rst), .d_i({hit, idx}), .q_o(sync_addr)
   );

   assign sh = sync_addr[k];
   assign si = sync_addr[k-1:0];

   always_comb begin
      state_d = state_q;
      ri_d    = ri_q;
      rc_any  = 1'b0;
      case (state_q)
         IDLE: if (ss && !ss_prev_q && sh) begin
            state_d = BUSY;
            ri_d    = si;
         end
         BUSY: if (!ss && ss_prev_q) begin
            state_d = IDLE;
            rc_any  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      frz = '0;
      rc  = '0;
      for (int unsigned i = 0; i < m; i++) begin
         frz[i] = (sh && si == i[k-1:0]) || (state_q == BUSY && ri_q == i[k-1:0]);
         rc[i]  = rc_any && (ri_q == i[k-1:0]);
      end
   end

   // A direct write beats both a pending value and a clear-on-read.
   always_comb begin
      bank_d  = bank_q;
      pend_d  = pend_q;
      pv_d    = pv_q;
      fresh_d = fresh_q;
      ovf_d   = ovf_q;
      for (int unsigned i = 0; i < m; i++) begin
         if (we[i]) begin
            fresh_d[i] = 1'b1;
            if (rc[i] || !frz[i]) begin
               bank_d[i] = d[i*n +: n];
               pv_d[i]   = 1'b0;
            end else begin
               pend_d[i] = d[i*n +: n];
               pv_d[i]   = 1'b1;
            end
         end else if (rc[i]) begin
            pv_d[i] = 1'b0;
            if (pv_q[i]) begin
               bank_d[i] = pend_q[i];
            end else begin
               fresh_d[i] = 1'b0;
               if (cor[i]) bank_d[i] = '0;
            end
         end else if (frz_q[i] && !frz[i] && pv_q[i]) begin
            bank_d[i] = pend_q[i];
            pv_d[i]   = 1'b0;
         end
         if (ovf_clr[i]) ovf_d[i] = 1'b0;
         if (we[i] && fresh_q[i] && !rc[i]) ovf_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ri_q       <= '0;
         ss_prev_q  <= 1'b0;
         frz_q      <= '0;
         bank_q     <= '0;
         pend_q     <= '0;
         pv_q       <= '0;
         fresh_q    <= '0;
         ovf_q      <= '0;
         rd_pulse_q <= '0;
      end else begin
         state_q    <= state_d;
         ri_q       <= ri_d;
         ss_prev_q  <= ss;
         frz_q      <= frz;
         bank_q     <= bank_d;
         pend_q     <= pend_d;
         pv_q       <= pv_d;
         fresh_q    <= fresh_d;
         ovf_q      <= ovf_d;
         rd_pulse_q <= rc;
      end
   end

   assign rd_pulse = rd_pulse_q;
   assign fresh    = fresh_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_spi_slave_regbank_r.sv
// Self-checking bench for spi_slave_regbank_r: directed scenarios plus random
// SPI transactions and clk-domain writes checked against a behavioural model.
module tb_spi_slave_regbank_r;

   localparam int          NS   = 2;
   localparam logic [7:0]  BASE = 8'h10;
   localparam logic [3:0]  COR  = 4'b0001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        strobe = 1'b0;
   logic [7:0]  addr = '0;
   logic [7:0]  in;
   logic        zo;
   logic [31:0] d = '0;
   logic [3:0]  we = '0;
   logic [3:0]  ovf_clr = '0;
   logic [3:0]  rd_pulse, fresh, ovf;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   spi_slave_regbank_r #(.n(8), .m(4), .a(BASE), .cor(COR), .ns(NS)) dut (
      .clk(clk), .rst(rst), .strobe(strobe), .addr(addr), .in(in), .zo(zo),
      .d(d), .we(we), .ovf_clr(ovf_clr), .rd_pulse(rd_pulse), .fresh(fresh), .ovf(ovf)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic bit f_hit(input logic [7:0] av);
      return (av >> 2) == (BASE >> 2);
   endfunction

   // ---------------- behavioural model ----------------
   int m_bank[4], m_pend[4];
   bit m_pv[4], m_fresh[4], m_ovf[4], m_pulse[4], m_frz_prev[4];
   int hs[NS+1], hh[NS+1], hi[NS+1];   // [0] = most recent sample
   bit m_reading;
   int m_reg;
   bit started = 0;

   always @(posedge clk) begin
      bit ss, ssp, sh, done, comp, frz;
      int si, di;
      started = 1;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_bank[i] = 0; m_pend[i] = 0; m_pv[i] = 0; m_fresh[i] = 0;
            m_ovf[i] = 0; m_pulse[i] = 0; m_frz_prev[i] = 0;
         end
         for (int j = 0; j <= NS; j++) begin hs[j] = 0; hh[j] = 0; hi[j] = 0; end
         m_reading = 0;
         m_reg = 0;
      end else begin
         ss   = hs[NS-1] != 0;
         ssp  = hs[NS] != 0;
         sh   = hh[NS-1] != 0;
         si   = hi[NS-1];
         done = m_reading && ssp && !ss;
         for (int i = 0; i < 4; i++) begin
            frz  = (sh && si == i) || (m_reading && m_reg == i);
            comp = done && m_reg == i;
            di   = (d >> (8*i)) & 255;
            m_pulse[i] = comp;
            if (we[i] && m_fresh[i] && !comp) m_ovf[i] = 1;
            else if (ovf_clr[i]) m_ovf[i] = 0;
            if (we[i]) begin
               m_fresh[i] = 1;
               if (comp || !frz) begin m_bank[i] = di; m_pv[i] = 0; end
               else begin m_pend[i] = di; m_pv[i] = 1; end
            end else if (comp) begin
               if (m_pv[i]) m_bank[i] = m_pend[i];
               else begin m_fresh[i] = 0; if (COR[i]) m_bank[i] = 0; end
               m_pv[i] = 0;
            end else if (m_frz_prev[i] && !frz && m_pv[i]) begin
               m_bank[i] = m_pend[i];
               m_pv[i] = 0;
            end
            m_frz_prev[i] = frz;
         end
         if (done) m_reading = 0;
         else if (!m_reading && ss && !ssp && sh) begin m_reading = 1; m_reg = si; end
         for (int j = NS; j > 0; j--) begin hs[j] = hs[j-1]; hh[j] = hh[j-1]; hi[j] = hi[j-1]; end
         hs[0] = strobe;
         hh[0] = f_hit(addr);
         hi[0] = addr % 4;
      end
   end

   always @(negedge clk) begin
      int exp_in;
      logic [3:0] ep, ef, eo;
      if (started) begin
         exp_in = (strobe && f_hit(addr)) ? m_bank[addr % 4] : 0;
         for (int i = 0; i < 4; i++) begin
            ep[i] = m_pulse[i]; ef[i] = m_fresh[i]; eo[i] = m_ovf[i];
         end
         chk("model_in", in, exp_in);
         chk("model_zo", zo, !(strobe && f_hit(addr)));
         chk("model_rd_pulse", rd_pulse, ep);
         chk("model_fresh", fresh, ef);
         chk("model_ovf", ovf, eo);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int r, input logic [7:0] v);
      we = '0;
      we[r] = 1'b1;
      d[r*8 +: 8] = v;
      tick();
      we = '0;
   endtask

   task automatic wait_pulse(input string name, input logic [3:0] exp);
      for (int c = 0; c < 12; c++) begin
         tick();
         if (rd_pulse != 0) break;
      end
      chk(name, rd_pulse, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] seen;
      int r, lo, hiw;
      rst = 1;
      repeat (3) tick();
      chk("rst_in", in, 0);
      chk("rst_zo", zo, 1);
      chk("rst_fresh", fresh, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_rd_pulse", rd_pulse, 0);
      rst = 0;
      tick();

      // basic read of reg 2
      wr(2, 8'hA5);
      chk("fresh2_set", fresh[2], 1);
      addr = 8'h12; strobe = 1;
      #1 chk("rd2_in", in, 8'hA5);
      chk("rd2_zo", zo, 0);
      repeat (4) tick();
      strobe = 0;
      wait_pulse("rd2_pulse", 4'b0100);
      chk("fresh2_clr", fresh[2], 0);
      tick();
      chk("rd2_pulse_one_clk", rd_pulse, 0);

      // deferred write during a read of reg 3
      addr = 8'h00;
      wr(3, 8'h11);
      addr = 8'h13;
      repeat (4) tick();
      strobe = 1;
      repeat (3) tick();
      wr(3, 8'h22);
      for (int c = 0; c < 4; c++) begin
         chk("frz3_in", in, 8'h11);
         tick();
      end
      strobe = 0;
      wait_pulse("rd3_pulse", 4'b1000);
      chk("fresh3_kept", fresh[3], 1);
      strobe = 1;
      #1 chk("rd3_new", in, 8'h22);
      repeat (4) tick();
      strobe = 0;
      wait_pulse("rd3b_pulse", 4'b1000);
      chk("fresh3_clr", fresh[3], 0);

      // clear-on-read reg 0
      addr = 8'h00;
      wr(0, 8'h7E);
      addr = 8'h10;
      repeat (3) tick();
      strobe = 1;
      #1 chk("cor_first", in, 8'h7E);
      repeat (4) tick();
      strobe = 0;
      wait_pulse("cor_pulse1", 4'b0001);
      strobe = 1;
      #1 chk("cor_second", in, 8'h00);
      repeat (4) tick();
      strobe = 0;
      wait_pulse("cor_pulse2", 4'b0001);

      // overflow on reg 1
      addr = 8'h00;
      repeat (3) tick();
      wr(1, 8'h01);
      chk("ovf1_single", ovf[1], 0);
      wr(1, 8'h02);
      chk("ovf1_set", ovf[1], 1);
      addr = 8'h11;
      repeat (3) tick();
      strobe = 1;
      #1 chk("rd1_in", in, 8'h02);
      repeat (4) tick();
      strobe = 0;
      wait_pulse("rd1_pulse", 4'b0010);
      chk("ovf1_sticky", ovf[1], 1);
      ovf_clr = 4'b0010;
      tick();
      ovf_clr = '0;
      chk("ovf1_clr", ovf[1], 0);

      // outside the bank
      addr = 8'h20; strobe = 1;
      #1 chk("miss_in", in, 0);
      chk("miss_zo", zo, 1);
      seen = '0;
      repeat (6) begin tick(); seen |= rd_pulse; end
      strobe = 0;
      repeat (6) begin tick(); seen |= rd_pulse; end
      chk("miss_no_pulse", seen, 0);

      // reset in the middle of a read
      addr = 8'h11; strobe = 1;
      repeat (5) tick();
      rst = 1; strobe = 0;
      repeat (4) tick();
      rst = 0;
      seen = '0;
      repeat (8) begin tick(); seen |= rd_pulse; end
      chk("rst_busy_no_pulse", seen, 0);
      strobe = 1;
      repeat (4) tick();
      strobe = 0;
      wait_pulse("after_rst_pulse", 4'b0010);

      // randomized transactions
      for (int t = 0; t < 300; t++) begin
         r = $urandom_range(0, 9);
         if (r < 7)      addr = BASE + 8'($urandom_range(0, 3));
         else if (r < 9) addr = 8'($urandom_range(0, 255));
         else            addr = 8'h14;
         lo  = $urandom_range(2, 5);
         hiw = $urandom_range(3, 8);
         for (int c = 0; c < lo + hiw; c++) begin
            strobe  = (c >= lo);
            we      = 4'($urandom & $urandom);
            d       = $urandom;
            ovf_clr = 4'($urandom & $urandom & $urandom);
            rst     = ($urandom_range(0, 399) == 0);
            tick();
         end
      end
      strobe = 0; we = '0; ovf_clr = '0; rst = 0;
      repeat (8) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
